// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per key, a two-flop synchroniser, a counter debounce FSM,
// registered press/release pulses and an optional hold-to-repeat pulse.
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_pressed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               RPT_EN    = (REPEAT_DELAY != 0);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_pressedNext;
  logic                r_anyPressed;

  // Sync flops reset to the released level so a held key is re-debounced after reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_anyPressed <= 1'b0;
    end else begin
      r_anyPressed <= |w_pressedNext;
    end
  end

  assign any_pressed = r_anyPressed;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcntNext;
    logic             r_firstDone;
    logic             w_firstDoneNext;
    logic             r_pressed;
    logic             r_pressPulse;
    logic             r_releasePulse;
    logic             r_repeatPulse;
    logic             w_pressed;
    logic             w_pressPulse;
    logic             w_releasePulse;
    logic             w_repeatPulse;
    logic             w_s;

    assign w_s = ~r_sync2[g];

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_state        <= IDLE;
        r_cnt          <= '0;
        r_rcnt         <= '0;
        r_firstDone    <= 1'b0;
        r_pressed      <= 1'b0;
        r_pressPulse   <= 1'b0;
        r_releasePulse <= 1'b0;
        r_repeatPulse  <= 1'b0;
      end else begin
        r_state        <= w_stateNext;
        r_cnt          <= w_cntNext;
        r_rcnt         <= w_rcntNext;
        r_firstDone    <= w_firstDoneNext;
        r_pressed      <= w_pressed;
        r_pressPulse   <= w_pressPulse;
        r_releasePulse <= w_releasePulse;
        r_repeatPulse  <= w_repeatPulse;
      end
    end

    // Repeat counter only advances in HELD, so a rejected release glitch freezes it
    always_comb begin
      w_stateNext     = r_state;
      w_cntNext       = r_cnt;
      w_rcntNext      = r_rcnt;
      w_firstDoneNext = r_firstDone;
      w_pressed       = r_pressed;
      w_pressPulse    = 1'b0;
      w_releasePulse  = 1'b0;
      w_repeatPulse   = 1'b0;
      case (r_state)
        IDLE: begin
          w_pressed = 1'b0;
          if (w_s) begin
            w_stateNext = PRESS_WAIT;
            w_cntNext   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            w_stateNext = IDLE;
          end else if (r_cnt == DEB_LAST) begin
            w_stateNext     = HELD;
            w_pressed       = 1'b1;
            w_pressPulse    = 1'b1;
            w_rcntNext      = '0;
            w_firstDoneNext = 1'b0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!w_s) begin
            w_stateNext = RELEASE_WAIT;
            w_cntNext   = '0;
          end else if (RPT_EN) begin
            if (r_rcnt == (r_firstDone ? RPT_NEXT : RPT_FIRST)) begin
              w_repeatPulse   = 1'b1;
              w_rcntNext      = '0;
              w_firstDoneNext = 1'b1;
            end else begin
              w_rcntNext = r_rcnt + CNT_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (w_s) begin
            w_stateNext = HELD;
          end else if (r_cnt == DEB_LAST) begin
            w_stateNext    = IDLE;
            w_pressed      = 1'b0;
            w_releasePulse = 1'b1;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_pressed   = 1'b0;
        end
      endcase
    end

    assign w_pressedNext[g] = w_pressed;
    assign pressed[g]       = r_pressed;
    assign press_pulse[g]   = r_pressPulse;
    assign release_pulse[g] = r_releasePulse;
    assign repeat_pulse[g]  = r_repeatPulse;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected per-cycle output vectors are queued
// as stimulus is planned and compared as each clock edge completes.
module tb_key_conditioner;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic [2:0] pressed, pressPulse, releasePulse, repeatPulse;
  logic       anyPressed;
  logic [2:0] nrPressed, nrPressPulse, nrReleasePulse, nrRepeatPulse;
  logic       nrAnyPressed;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [2:0] pressed;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] rpt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  key_conditioner #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(6), .REPEAT_PERIOD(3), .CNT_W(25)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n),
    .pressed(pressed), .press_pulse(pressPulse), .release_pulse(releasePulse),
    .repeat_pulse(repeatPulse), .any_pressed(anyPressed)
  );

  // Same stimulus with auto-repeat disabled
  key_conditioner #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3), .CNT_W(25)
  ) dutNoRpt (
    .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n),
    .pressed(nrPressed), .press_pulse(nrPressPulse), .release_pulse(nrReleasePulse),
    .repeat_pulse(nrRepeatPulse), .any_pressed(nrAnyPressed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic pushExp(input int c, input logic [2:0] p, input logic [2:0] pp,
                         input logic [2:0] rp, input logic [2:0] rr, input string tag);
    exp_t e;
    e.cyc = c; e.pressed = p; e.press = pp; e.rel = rp; e.rpt = rr; e.tag = tag;
    sb.push_back(e);
  endtask

  // One edge, then compare on the falling edge against any queued expectation
  task automatic stepCycle();
    exp_t e;
    @(posedge CLOCK_50);
    cyc++;
    @(negedge CLOCK_50);
    checkOutput("norepeat.repeat_pulse", nrRepeatPulse, 3'b000);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".pressed"}, pressed, e.pressed);
      checkOutput({e.tag, ".press_pulse"}, pressPulse, e.press);
      checkOutput({e.tag, ".release_pulse"}, releasePulse, e.rel);
      checkOutput({e.tag, ".repeat_pulse"}, repeatPulse, e.rpt);
      checkOutput({e.tag, ".any_pressed"}, {2'b00, anyPressed}, {2'b00, |e.pressed});
    end
  endtask

  task automatic applyStimulus(input logic [2:0] keys, input int untilCyc);
    key_n = keys;
    while (cyc < untilCyc) stepCycle();
  endtask

  initial begin
    reset = 1'b1;
    key_n = 3'b111;
    pushExp(1, 3'b000, 3'b000, 3'b000, 3'b000, "reset");
    pushExp(2, 3'b000, 3'b000, 3'b000, 3'b000, "reset");
    applyStimulus(3'b111, 2);
    reset = 1'b0;

    // Key 1 press at edge 10, glitch at edge 30, release at edge 40
    for (int c = 11; c <= 47; c++)
      pushExp(c, (c >= 16 && c < 46) ? 3'b010 : 3'b000,
              (c == 16) ? 3'b010 : 3'b000,
              (c == 46) ? 3'b010 : 3'b000,
              (c inside {22, 25, 28, 31, 36, 39}) ? 3'b010 : 3'b000,
              (c <= 17) ? "press_key1" : "hold_release_key1");
    applyStimulus(3'b111, 9);
    applyStimulus(3'b101, 29);
    applyStimulus(3'b111, 30);
    applyStimulus(3'b101, 39);
    applyStimulus(3'b111, 49);

    // Key 0 bounces: 3 low, 1 high, five times
    for (int c = 50; c <= 76; c++)
      pushExp(c, 3'b000, 3'b000, 3'b000, 3'b000, "bounce_key0");
    for (int r = 0; r < 5; r++) begin
      applyStimulus(3'b110, cyc + 3);
      applyStimulus(3'b111, cyc + 1);
    end
    applyStimulus(3'b111, 79);

    // Key 2 auto-repeat: press at edge 80, release at edge 103
    for (int c = 80; c <= 110; c++)
      pushExp(c, (c >= 86 && c < 109) ? 3'b100 : 3'b000,
              (c == 86) ? 3'b100 : 3'b000,
              (c == 109) ? 3'b100 : 3'b000,
              (c inside {92, 95, 98, 101, 104}) ? 3'b100 : 3'b000,
              "repeat_key2");
    applyStimulus(3'b011, 102);
    applyStimulus(3'b111, 114);

    // Key 1 held through a one-cycle reset at edge 125
    for (int c = 116; c <= 143; c++)
      pushExp(c, ((c >= 121 && c <= 124) || (c >= 132 && c <= 140)) ? 3'b010 : 3'b000,
              (c == 121 || c == 132) ? 3'b010 : 3'b000,
              (c == 141) ? 3'b010 : 3'b000,
              3'b000, "reset_mid_hold");
    applyStimulus(3'b101, 124);
    reset = 1'b1;
    applyStimulus(3'b101, 125);
    reset = 1'b0;
    applyStimulus(3'b101, 134);
    applyStimulus(3'b111, 149);

    // All keys together: press at edge 150, release at edge 160
    for (int c = 151; c <= 168; c++)
      pushExp(c, (c >= 156 && c <= 165) ? 3'b111 : 3'b000,
              (c == 156) ? 3'b111 : 3'b000,
              (c == 166) ? 3'b111 : 3'b000,
              3'b000, "simultaneous");
    applyStimulus(3'b000, 159);
    applyStimulus(3'b111, 170);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
